// File: rtl/seq_controller_pkg.sv
// seq_controller_pkg: shared definitions for the 8-phase instruction sequencer.
//   - opcode encoding (HLT..JMP)
//   - sequencer state encoding (RUN, WAIT, HALTED)
//   - phase constants for fetch (0-3), decode (4) and execute (5-7)
//   - wait-state range limit and counter width
//   - control strobe bundle and the memory-read opcode class helper
package seq_controller_pkg;

  localparam int unsigned OP_W     = 3;
  localparam int unsigned PHASE_W  = 3;
  localparam int unsigned WAIT_MAX = 15;
  localparam int unsigned CNT_W    = 4;

  typedef enum logic [OP_W-1:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_WAIT   = 2'd1,
    ST_HALTED = 2'd2
  } seq_state_e;

  // Fetch phases
  localparam logic [PHASE_W-1:0] PH_FETCH0 = 3'd0;
  localparam logic [PHASE_W-1:0] PH_FETCH1 = 3'd1;
  localparam logic [PHASE_W-1:0] PH_FETCH2 = 3'd2;
  localparam logic [PHASE_W-1:0] PH_FETCH3 = 3'd3;
  // Decode phase
  localparam logic [PHASE_W-1:0] PH_DECODE = 3'd4;
  // Execute phases
  localparam logic [PHASE_W-1:0] PH_EXEC0  = 3'd5;
  localparam logic [PHASE_W-1:0] PH_EXEC1  = 3'd6;
  localparam logic [PHASE_W-1:0] PH_EXEC2  = 3'd7;

  // Datapath control bundle
  typedef struct packed {
    logic sel;
    logic rd;
    logic ld_ir;
    logic inc_pc;
    logic halt;
    logic ld_pc;
    logic data_e;
    logic ld_ac;
    logic wr;
  } ctrl_t;

  // Opcodes that read memory into the accumulator during execute
  function automatic logic is_mem_read(opcode_e op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/seq_phase_gen.sv
// seq_phase_gen: phase register, wait counter and RUN/WAIT/HALTED state.
// Optional feature macro: SEQ_CTRL_WAIT_EN (compiles in wait-state insertion).
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   run            restart request, honoured only in HALTED
//   halt_req_c     HLT decoded in phase 4 while running
//   mem_rd_c       current opcode is a memory-read instruction
//   state          current sequencer state
//   phase          registered phase 0..7
//   waiting        registered, high on every inserted wait cycle
module seq_phase_gen
  import seq_controller_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               halt_req_c,
  input  logic               mem_rd_c,
  output seq_state_e         state,
  output logic [PHASE_W-1:0] phase,
  output logic               waiting
);

  seq_state_e         state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               wait_req_c;
  logic               wait_done_c;

`ifdef SEQ_CTRL_WAIT_EN
  localparam int unsigned WAIT_EFF = (WAIT_CYCLES > WAIT_MAX) ? WAIT_MAX : WAIT_CYCLES;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             waiting_q, waiting_d;

  // Read-access phases: fetch read always, execute read only for memory reads
  assign wait_req_c  = (WAIT_EFF != 0) &&
                       ((phase_q == PH_FETCH1) || ((phase_q == PH_EXEC0) && mem_rd_c));
  assign wait_done_c = (cnt_q == CNT_W'(1));

  // Wait counter: loaded on WAIT entry, counts down, lands on 0 at exit
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == ST_RUN) && wait_req_c && !halt_req_c) begin
      cnt_d = CNT_W'(WAIT_EFF);
    end else if (state_q == ST_WAIT) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  assign waiting_d = (state_d == ST_WAIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      waiting_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      waiting_q <= waiting_d;
    end
  end

  assign waiting = waiting_q;
`else
  logic unused_wait_cfg;

  assign wait_req_c      = 1'b0;
  assign wait_done_c     = 1'b1;
  assign waiting         = 1'b0;
  assign unused_wait_cfg = ^{mem_rd_c, CNT_W'(WAIT_CYCLES)};
`endif

  // Next-state and phase sequencing
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    unique case (state_q)
      ST_RUN: begin
        if (halt_req_c) begin
          state_d = ST_HALTED;
        end else if (wait_req_c) begin
          state_d = ST_WAIT;
        end else begin
          phase_d = phase_q + PHASE_W'(1);
        end
      end
      ST_WAIT: begin
        if (wait_done_c) begin
          state_d = ST_RUN;
          phase_d = phase_q + PHASE_W'(1);
        end
      end
      ST_HALTED: begin
        // Resume with the execute phases of the HLT instruction
        if (run) begin
          state_d = ST_RUN;
          phase_d = PH_EXEC0;
        end
      end
      default: begin
        state_d = ST_RUN;
        phase_d = PH_FETCH0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      phase_q <= PH_FETCH0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  assign state = state_q;
  assign phase = phase_q;

endmodule

// File: rtl/seq_controller.sv
// seq_controller: 8-phase instruction sequencer with datapath strobe decode,
// optional memory wait states on read phases and a halted state with restart.
// Optional feature macro: SEQ_CTRL_WAIT_EN (wait-state insertion; otherwise
// WAIT_CYCLES is ignored and waiting is tied low).
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   opcode [OPWIDTH]         current instruction opcode; values above 7 are no-ops
//   zero                     accumulator-zero flag
//   run                      restart request, sampled only while halted
//   phase [3], waiting       registered sequencer phase and wait indicator
//   sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr
//                            combinational datapath controls
module seq_controller
  import seq_controller_pkg::*;
#(
  parameter int unsigned OPWIDTH     = 3,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OPWIDTH-1:0] opcode,
  input  logic               zero,
  input  logic               run,
  output logic [PHASE_W-1:0] phase,
  output logic               waiting,
  output logic               sel,
  output logic               rd,
  output logic               ld_ir,
  output logic               inc_pc,
  output logic               halt,
  output logic               ld_pc,
  output logic               data_e,
  output logic               ld_ac,
  output logic               wr
);

  // Extended view so the "above 7" test is a real comparison for any width
  localparam int unsigned OPW_EXT = (OPWIDTH > OP_W) ? OPWIDTH : OP_W + 1;

  logic [OPW_EXT-1:0] op_ext_c;
  logic               nop_c;
  opcode_e            op_c;
  logic               mem_rd_c;
  logic               halt_req_c;
  seq_state_e         state_c;
  ctrl_t              ctrl_c;

  assign op_ext_c   = OPW_EXT'(opcode);
  assign nop_c      = (op_ext_c > OPW_EXT'(7));
  assign op_c       = opcode_e'(op_ext_c[OP_W-1:0]);
  assign mem_rd_c   = !nop_c && is_mem_read(op_c);
  assign halt_req_c = (state_c == ST_RUN) && (phase == PH_DECODE) &&
                      !nop_c && (op_c == OP_HLT);

  seq_phase_gen #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_phase_gen (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .halt_req_c (halt_req_c),
    .mem_rd_c   (mem_rd_c),
    .state      (state_c),
    .phase      (phase),
    .waiting    (waiting)
  );

  // Strobe decode: levels follow phase in RUN and WAIT, one-cycle strobes only in RUN
  always_comb begin
    ctrl_c = '0;
    unique case (state_c)
      ST_HALTED: begin
        ctrl_c.halt = 1'b1;
      end
      ST_RUN, ST_WAIT: begin
        ctrl_c.sel    = (phase <= PH_FETCH3);
        ctrl_c.rd     = ((phase >= PH_FETCH1) && (phase <= PH_FETCH3)) ||
                        ((phase >= PH_EXEC0) && mem_rd_c);
        ctrl_c.data_e = (phase >= PH_EXEC1) && !nop_c && (op_c == OP_STO);
        if (state_c == ST_RUN) begin
          ctrl_c.ld_ir  = (phase == PH_FETCH2) || (phase == PH_FETCH3);
          ctrl_c.inc_pc = (phase == PH_DECODE) ||
                          ((phase == PH_EXEC1) && !nop_c && (op_c == OP_SKZ) && zero);
          ctrl_c.halt   = halt_req_c;
          ctrl_c.ld_pc  = (phase >= PH_EXEC1) && !nop_c && (op_c == OP_JMP);
          ctrl_c.ld_ac  = (phase == PH_EXEC2) && mem_rd_c;
          ctrl_c.wr     = (phase == PH_EXEC2) && !nop_c && (op_c == OP_STO);
        end
      end
      default: begin
        ctrl_c = '0;
      end
    endcase
  end

  assign sel    = ctrl_c.sel;
  assign rd     = ctrl_c.rd;
  assign ld_ir  = ctrl_c.ld_ir;
  assign inc_pc = ctrl_c.inc_pc;
  assign halt   = ctrl_c.halt;
  assign ld_pc  = ctrl_c.ld_pc;
  assign data_e = ctrl_c.data_e;
  assign ld_ac  = ctrl_c.ld_ac;
  assign wr     = ctrl_c.wr;

endmodule

// File: tb/tb_seq_controller.sv
// tb_seq_controller: self-checking bench for seq_controller (WAIT_CYCLES=2).
// Expected behaviour is derived from a per-instruction cycle schedule built
// from the phase/wait/halt rules, plus a per-phase strobe table.
module tb_seq_controller;

  localparam int unsigned WC = 2;
`ifdef SEQ_CTRL_WAIT_EN
  localparam int unsigned W_EFF = WC;
`else
  localparam int unsigned W_EFF = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       run;
  logic [2:0] phase;
  logic       waiting;
  logic       sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
  logic [8:0] obs_ctrl;

  int checks = 0;
  int errors = 0;
  logic wr_seen;

  typedef struct {
    int ph;
    bit w;
    bit h;
  } step_t;

  step_t sched[$];

  always #5 clk = ~clk;

  assign obs_ctrl = {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr};

  seq_controller #(
    .OPWIDTH     (3),
    .WAIT_CYCLES (WC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .opcode  (opcode),
    .zero    (zero),
    .run     (run),
    .phase   (phase),
    .waiting (waiting),
    .sel     (sel),
    .rd      (rd),
    .ld_ir   (ld_ir),
    .inc_pc  (inc_pc),
    .halt    (halt),
    .ld_pc   (ld_pc),
    .data_e  (data_e),
    .ld_ac   (ld_ac),
    .wr      (wr)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Strobe table: {sel,rd,ld_ir,inc_pc,halt,ld_pc,data_e,ld_ac,wr}
  function automatic logic [8:0] exp_ctrl(int op, bit z, int ph, bit w, bit h);
    bit mem;
    bit s, r, li, ip, hl, lp, de, la, wv;
    mem = (op >= 2) && (op <= 5);
    {s, r, li, ip, hl, lp, de, la, wv} = '0;
    if (h) begin
      hl = 1'b1;
    end else begin
      s  = (ph < 4);
      r  = ((ph >= 1) && (ph <= 3)) || ((ph >= 5) && mem);
      de = (ph >= 6) && (op == 6);
      if (!w) begin
        li = (ph == 2) || (ph == 3);
        ip = (ph == 4) || ((ph == 6) && (op == 1) && z);
        hl = (ph == 4) && (op == 0);
        lp = (ph >= 6) && (op == 7);
        la = (ph == 7) && mem;
        wv = (ph == 7) && (op == 6);
      end
    end
    return {s, r, li, ip, hl, lp, de, la, wv};
  endfunction

  // One entry per clock cycle of an instruction
  task automatic build(input int op, input int halted_n);
    step_t st;
    sched.delete();
    for (int p = 0; p < 8; p++) begin
      st.ph = p; st.w = 1'b0; st.h = 1'b0;
      sched.push_back(st);
      if ((p == 4) && (op == 0)) begin
        for (int k = 0; k < halted_n; k++) begin
          st.ph = 4; st.w = 1'b0; st.h = 1'b1;
          sched.push_back(st);
        end
      end
      if ((p == 1) || ((p == 5) && (op >= 2) && (op <= 5))) begin
        for (int k = 0; k < int'(W_EFF); k++) begin
          st.ph = p; st.w = 1'b1; st.h = 1'b0;
          sched.push_back(st);
        end
      end
    end
  endtask

  // zmode: 0/1 fixed zero, 2 random. abort_mode: 0 none, 1 first phase-5
  // cycle, 2 second phase-5 wait cycle (first phase-5 cycle if none).
  task automatic run_instr(input int op, input int zmode, input int halted_n, input int abort_mode);
    int abort_at;
    int nw5;
    build(op, halted_n);
    abort_at = -1;
    nw5 = 0;
    if (abort_mode != 0) begin
      foreach (sched[i]) begin
        if ((sched[i].ph == 5) && (abort_at < 0)) abort_at = i;
        if ((abort_mode == 2) && (sched[i].ph == 5) && sched[i].w) begin
          nw5++;
          if (nw5 == 2) abort_at = i;
        end
      end
    end
    wr_seen = 1'b0;
    foreach (sched[i]) begin
      opcode = 3'(op);
      zero   = (zmode == 2) ? 1'($urandom) : 1'(zmode);
      if (sched[i].h) run = (i + 1 < sched.size()) && !sched[i+1].h;
      else            run = 1'($urandom);
      #1;
      check("phase", 16'(phase), 16'(sched[i].ph));
      check("waiting", 16'(waiting), 16'(sched[i].w));
      check("ctrl", 16'(obs_ctrl), 16'(exp_ctrl(op, zero, sched[i].ph, sched[i].w, sched[i].h)));
      wr_seen = wr_seen | wr;
      if (i == abort_at) begin
        #1 rst = 1'b0;
        #1;
        check("rst_phase", 16'(phase), 16'd0);
        check("rst_waiting", 16'(waiting), 16'd0);
        check("rst_ctrl", 16'(obs_ctrl), 16'h100);
        check("no_wr", 16'(wr_seen), 16'd0);
        @(negedge clk); #1;
        check("rst_hold_phase", 16'(phase), 16'd0);
        rst = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  // Observe instruction length and inserted wait count straight from the DUT
  task automatic measure(input int op, input int exp_len, input int exp_waits);
    int n;
    int w;
    opcode = 3'(op);
    zero   = 1'b0;
    run    = 1'b0;
    #1;
    n = 0;
    w = 0;
    do begin
      w += int'(waiting);
      n++;
      @(negedge clk); #1;
    end while ((phase != 3'd0) && (n < 64));
    check("instr_len", 16'(n), 16'(exp_len));
    check("wait_cycles", 16'(w), 16'(exp_waits));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b0;
    opcode = 3'd2;
    zero   = 1'b0;
    run    = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_phase", 16'(phase), 16'd0);
    check("reset_waiting", 16'(waiting), 16'd0);
    check("reset_ctrl", 16'(obs_ctrl), 16'h100);
    rst = 1'b1;

    run_instr(2, 2, 0, 0);        // ADD
    run_instr(1, 1, 0, 0);        // SKZ, zero=1
    run_instr(1, 0, 0, 0);        // SKZ, zero=0
    run_instr(0, 2, 6, 0);        // HLT, 5 idle halted cycles then run
    measure(5, 8 + 2 * int'(W_EFF), 2 * int'(W_EFF));   // LDA
    measure(6, 8 + int'(W_EFF), int'(W_EFF));          // STO
    measure(7, 8 + int'(W_EFF), int'(W_EFF));          // JMP

    for (int n = 0; n < 40; n++) begin
      run_instr(int'($urandom_range(0, 7)), 2, int'($urandom_range(1, 4)), 0);
    end

    run_instr(6, 2, 0, 1);        // STO, reset in phase 5
    run_instr(2, 2, 0, 0);        // fetch resumes
    run_instr(5, 2, 0, 2);        // LDA, reset mid execute wait
    run_instr(3, 2, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
